mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: instruction fetch (IF) and the MEM-stage load/store.
- Sits between the pipeline and the memory block. It replaces the implicit time-multiplexing of the memory with an explicit request/grant/response handshake.
- Drives a `busy` indication so the hazard logic can stall IF/ID or EX/MEM while an access is in flight.

Parameters:
- ADDR_W, 9, memory byte-address width.
- MEM_LAT, 1, cycles from a memory enable edge to valid mem_rdata; legal range is ≥1.
- STARVE_LIM, 4, consecutive lost arbitrations after which fetch is forced to win (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted (one-cycle pulse)
- if_rvalid  out  1  fetch data valid (one-cycle pulse)
- if_rdata  out  32  fetched word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_func3  in  3  access size/sign, forwarded to memory
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_gnt  out  1  data granted (one-cycle pulse)
- d_rvalid  out  1  load data / store completion (one-cycle pulse)
- d_rdata  out  32  load data; 0 for stores
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_func3  out  3  memory size/sign
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  a transaction is outstanding (state WAIT)

Behaviour:
- One clock (clk). rst is asynchronous and active-high.
- On reset:
  - FSM goes to IDLE; all outputs are 0; the owner register clears; the starvation counter clears.
  - Any in-flight transaction is dropped; no rvalid is issued for it.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: arbitrate. If any request is pending, grant one and go to WAIT with the latency counter = MEM_LAT−1; otherwise stay in IDLE.
  - WAIT: decrement the counter. When it reads 0, capture mem_rdata into the response register and go to RESP.
  - RESP: pulse rvalid for the owner, with the captured data. Arbitrate in the same cycle exactly as in IDLE: on a grant go to WAIT, otherwise go to IDLE.
- Arbitration policy: data has priority over fetch. Only one transaction is outstanding at a time.
- Grant cycle:
  - The gnt pulse for the winner is combinational in the grant cycle.
  - mem_en=1 and mem_addr/mem_we/mem_func3/mem_wdata are muxed combinationally from the winner.
  - For a fetch: mem_we=0 and mem_func3=3'b010.
- Outside the grant cycle, mem_en=0 and mem_we=0. The other mem_* outputs hold their last values.
- Latency: grant in cycle T; rvalid in cycle T+MEM_LAT+1. The next grant is possible in cycle T+MEM_LAT+1. Throughput is one access per MEM_LAT+1 cycles.
- Store completion: a store is committed at the grant edge. d_rvalid still pulses at T+MEM_LAT+1 with d_rdata=0.
- Response data hold: if_rdata and d_rdata hold their last value between pulses. Only the owner's rdata updates.
- Simultaneous requests: d wins; if_req stays pending and is served at the next arbitration point with no d_req.
- A requester dropping req before its grant is legal: the request is simply not served.
- busy=1 exactly in WAIT.

Optional Feature:
- Macro: FETCH_ANTISTARVE_EN.
- When defined:
  - A counter of width $clog2(STARVE_LIM+1) increments on each arbitration in which if_req=1 but d wins.
  - When the counter equals STARVE_LIM, fetch wins the next arbitration even if d_req=1.
  - The counter clears on every fetch grant and on reset.
- When undefined: strict data priority and no counter logic.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {IDLE, WAIT, RESP};
  - the owner encoding {OWN_IF, OWN_D};
  - localparam FETCH_FUNC3 = 3'b010.
- One natural combinational sub-module, mem_arb_pick: takes the two reqs plus the starve flag and returns the winner and the grant-valid signal.

Test Plan:
- Lone fetch, MEM_LAT=1: if_req with addr 0x010 at cycle 0 → if_gnt=1 and mem_en=1 at cycle 0; if_rvalid=1 at cycle 2 with if_rdata = mem word at 0x010; busy=1 in cycle 1 only.
- Simultaneous reqs: if_req and d_req (load 0x080) at cycle 0 → d_gnt at cycle 0, d_rvalid at 2; if_gnt at 2, if_rvalid at 4.
- Store: d_req, d_we=1, d_addr 0x100, d_wdata 0xDEADBEEF, d_func3 3'b010 → mem_we=1 at grant; d_rvalid 2 cycles later with d_rdata=0; a later load of 0x100 returns 0xDEADBEEF.
- MEM_LAT=3 back-to-back loads → grants at 0 and 4, rvalids at 4 and 8; busy high in cycles 1–3 and 5–7.
- Reset mid-WAIT: assert rst in cycle 1 after a grant → all outputs 0 immediately; no rvalid follows; the next if_req is granted in the first cycle after rst deasserts.
- FETCH_ANTISTARVE_EN, STARVE_LIM=4: d_req and if_req held high continuously → 4 data grants, then 1 fetch grant, repeating; with the macro undefined, only data grants occur.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, owner
// encoding and the access size used for instruction fetches.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   // Fetches are always full 32-bit words.
   localparam logic [2:0] FETCH_FUNC3 = 3'b010;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection. Data beats fetch unless the starve flag
// says fetch has lost too many times in a row and is still asking.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   if_req_i,
   input  logic   d_req_i,
   input  logic   starve_i,
   output owner_e winner_o,
   output logic   valid_o
);

   // Pick the winner among the pending requests.
   always_comb begin
      valid_o  = if_req_i | d_req_i;
      winner_o = OWN_IF;
      if (d_req_i && !(starve_i && if_req_i)) begin
         winner_o = OWN_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the MEM-stage
// load/store. One access is outstanding at a time; grants are combinational,
// responses come back as registered one-cycle rvalid pulses.
// Optional macro FETCH_ANTISTARVE_EN: after STARVE_LIM consecutive lost
// arbitrations fetch is forced to win the next one.
// Handshake: a requester holds req (and its address/data) until it sees gnt
// high in a cycle; the access is taken at the end of that cycle. The matching
// rvalid pulses MEM_LAT+1 cycles after the grant cycle.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 9,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_func3,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [2:0]        mem_func3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);

   localparam int             CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

   arb_state_e        state_q;
   logic [CNT_W-1:0]  lat_q;
   owner_e            owner_q;
   logic              we_q;
   logic              busy_q;
   logic              if_rvalid_q, d_rvalid_q;
   logic [31:0]       if_rdata_q, d_rdata_q;
   logic [2:0]        mem_func3_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;

   owner_e            winner;
   logic              pick_valid;
   logic              starve;
   logic              grant;

   mem_arb_pick u_pick (
      .if_req_i (if_req),
      .d_req_i  (d_req),
      .starve_i (starve),
      .winner_o (winner),
      .valid_o  (pick_valid)
   );

   // Arbitration happens in IDLE and RESP; reset blocks any grant so that
   // every output reads 0 while rst is high.
   always_comb begin
      grant     = !rst && (state_q != WAIT) && pick_valid;
      if_gnt    = grant && (winner == OWN_IF);
      d_gnt     = grant && (winner == OWN_D);
      mem_en    = grant;
      mem_we    = d_gnt && d_we;
      mem_func3 = mem_func3_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
      if (d_gnt) begin
         mem_func3 = d_func3;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (if_gnt) begin
         mem_func3 = FETCH_FUNC3;
         mem_addr  = if_addr;
      end
   end

`ifdef FETCH_ANTISTARVE_EN
   localparam int SC_W = $clog2(STARVE_LIM + 1);
   logic [SC_W-1:0] starve_q;

   assign starve = (starve_q == SC_W'(STARVE_LIM));

   // Count arbitrations fetch lost while asking; any fetch grant clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else if (if_gnt) begin
         starve_q <= '0;
      end else if (d_gnt && if_req) begin
         starve_q <= starve_q + SC_W'(1);
      end
   end
`else
   // Strict data priority: the flag can never be raised (comparison keeps
   // the limit parameter referenced in this build).
   assign starve = (STARVE_LIM < 0);
`endif

   // Request/wait/response FSM with registered rvalid, rdata and busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         lat_q       <= '0;
         owner_q     <= OWN_IF;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         mem_func3_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         case (state_q)
            WAIT: begin
               if (lat_q == '0) begin
                  state_q <= RESP;
                  busy_q  <= 1'b0;
                  if (owner_q == OWN_D) begin
                     d_rvalid_q <= 1'b1;
                     d_rdata_q  <= we_q ? 32'd0 : mem_rdata;
                  end else begin
                     if_rvalid_q <= 1'b1;
                     if_rdata_q  <= mem_rdata;
                  end
               end else begin
                  lat_q <= lat_q - CNT_W'(1);
               end
            end
            default: begin
               if (grant) begin
                  state_q     <= WAIT;
                  busy_q      <= 1'b1;
                  lat_q       <= LAT_INIT;
                  owner_q     <= winner;
                  we_q        <= mem_we;
                  mem_func3_q <= mem_func3;
                  mem_addr_q  <= mem_addr;
                  mem_wdata_q <= mem_wdata;
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all cycles checked against a transaction-level model (grant schedule,
// response queue, held data). Honours FETCH_ANTISTARVE_EN.
module tb_mem_port_arbiter;

   localparam int ADDR_W     = 9;
   localparam int MEM_LAT    = 3;
   localparam int STARVE_LIM = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_gnt, if_rvalid;
   logic [31:0]       if_rdata;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [2:0]        d_func3 = 3'b010;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [31:0]       d_wdata = '0;
   logic              d_gnt, d_rvalid;
   logic [31:0]       d_rdata;
   logic              mem_en, mem_we;
   logic [2:0]        mem_func3;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   mem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .MEM_LAT    (MEM_LAT),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_func3   (d_func3),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_func3 (mem_func3),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Memory block: word array, read data valid MEM_LAT cycles after the enable edge
   logic [31:0] mem [0:127];
   logic [31:0] rd_pipe [0:MEM_LAT-1];
   assign mem_rdata = rd_pipe[MEM_LAT-1];

   always @(posedge clk) begin
      if (mem_en) begin
         rd_pipe[0] <= mem[mem_addr[ADDR_W-1:2]];
         if (mem_we) mem[mem_addr[ADDR_W-1:2]] <= mem_wdata;
      end
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] <= $urandom;
      for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] <= '0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: arbitration slots, expected response queue, held values
   int                cyc = 0;
   int                next_arb = 0;
   int                starve_n = 0;
   logic [31:0]       exp_q[$];
   logic              own_q[$];
   int                due_q[$];
   logic [31:0]       if_rdata_e = '0, d_rdata_e = '0, wdata_e = '0;
   logic [ADDR_W-1:0] addr_e = '0;
   logic [2:0]        func3_e = '0;

   always @(negedge clk) begin
      logic e_ifg, e_dg, e_we, e_ifv, e_dv, e_busy, fetch_wins, starve_hit;
      e_ifg = 1'b0; e_dg = 1'b0; e_we = 1'b0; e_ifv = 1'b0; e_dv = 1'b0; e_busy = 1'b0;
      if (rst) begin
         exp_q.delete(); own_q.delete(); due_q.delete();
         cyc = 0; next_arb = 0; starve_n = 0;
         if_rdata_e = '0; d_rdata_e = '0; wdata_e = '0; addr_e = '0; func3_e = '0;
      end else begin
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            if (own_q[0]) begin e_dv = 1'b1; d_rdata_e = exp_q[0]; end
            else begin e_ifv = 1'b1; if_rdata_e = exp_q[0]; end
            void'(due_q.pop_front()); void'(own_q.pop_front()); void'(exp_q.pop_front());
         end
         e_busy = (due_q.size() > 0);
         if (cyc >= next_arb && (if_req || d_req)) begin
`ifdef FETCH_ANTISTARVE_EN
            starve_hit = (starve_n == STARVE_LIM);
`else
            starve_hit = 1'b0;
`endif
            fetch_wins = if_req && (!d_req || starve_hit);
            if (fetch_wins) begin
               e_ifg = 1'b1; starve_n = 0;
               addr_e = if_addr; func3_e = 3'b010;
               exp_q.push_back(mem[if_addr[ADDR_W-1:2]]); own_q.push_back(1'b0);
            end else begin
               e_dg = 1'b1; e_we = d_we;
               if (if_req) starve_n++;
               addr_e = d_addr; func3_e = d_func3; wdata_e = d_wdata;
               exp_q.push_back(d_we ? 32'd0 : mem[d_addr[ADDR_W-1:2]]); own_q.push_back(1'b1);
            end
            due_q.push_back(cyc + MEM_LAT + 1);
            next_arb = cyc + MEM_LAT + 1;
         end
         cyc++;
      end
      check("if_gnt", if_gnt, e_ifg);
      check("d_gnt", d_gnt, e_dg);
      check("mem_en", mem_en, e_ifg | e_dg);
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, addr_e);
      check("mem_func3", mem_func3, func3_e);
      check("mem_wdata", mem_wdata, wdata_e);
      check("busy", busy, e_busy);
      check("if_rvalid", if_rvalid, e_ifv);
      check("d_rvalid", d_rvalid, e_dv);
      check("if_rdata", if_rdata, if_rdata_e);
      check("d_rdata", d_rdata, d_rdata_e);
   end

   // Driver helpers
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Called one cycle after the grant edge; lat counts cycles since grant.
   task automatic wait_resp(input bit want_d, output int lat, output logic [31:0] data);
      lat = -1;
      data = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (want_d ? d_rvalid : if_rvalid) begin
            lat = i;
            data = want_d ? d_rdata : if_rdata;
            break;
         end
         if (i < 20) next_cycle();
      end
   endtask

   initial begin
      int          lat, ig_at, dv_at, icnt, dcnt, first_if, rv_cnt;
      logic [31:0] data, exp_word;
      logic        ig, dg;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_if_rdata", if_rdata, 0);
      next_cycle();
      rst = 1'b0;

      // Lone fetch of 0x010
      next_cycle();
      if_req = 1'b1; if_addr = 9'h010; exp_word = mem[4];
      @(negedge clk);
      check("fetch_gnt", if_gnt, 1);
      check("fetch_mem_en", mem_en, 1);
      next_cycle();
      if_req = 1'b0;
      wait_resp(1'b0, lat, data);
      check("fetch_lat", lat, MEM_LAT + 1);
      check("fetch_data", data, exp_word);

      // Simultaneous fetch and load: data first, fetch at the next slot
      next_cycle();
      if_req = 1'b1; if_addr = 9'h020;
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h080; d_func3 = 3'b010;
      @(negedge clk);
      check("simul_d_gnt", d_gnt, 1);
      check("simul_if_gnt0", if_gnt, 0);
      next_cycle();
      d_req = 1'b0;
      ig_at = -1; dv_at = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (d_rvalid) dv_at = i;
         if (if_gnt) begin ig_at = i; break; end
         next_cycle();
      end
      check("simul_d_rv_at", dv_at, MEM_LAT + 1);
      check("simul_if_gnt_at", ig_at, MEM_LAT + 1);
      next_cycle();
      if_req = 1'b0;
      wait_resp(1'b0, lat, data);
      check("simul_if_lat", lat, MEM_LAT + 1);

      // Store then load back
      next_cycle();
      d_req = 1'b1; d_we = 1'b1; d_addr = 9'h100; d_wdata = 32'hDEADBEEF; d_func3 = 3'b010;
      @(negedge clk);
      check("store_mem_we", mem_we, 1);
      check("store_wdata", mem_wdata, 32'hDEADBEEF);
      next_cycle();
      d_req = 1'b0; d_we = 1'b0;
      wait_resp(1'b1, lat, data);
      check("store_lat", lat, MEM_LAT + 1);
      check("store_rdata", data, 0);
      next_cycle();
      d_req = 1'b1; d_addr = 9'h100;
      @(negedge clk);
      check("reload_gnt", d_gnt, 1);
      next_cycle();
      d_req = 1'b0;
      wait_resp(1'b1, lat, data);
      check("reload_data", data, 32'hDEADBEEF);

      // Back-to-back loads: second grant lands on the first response cycle
      next_cycle();
      d_req = 1'b1; d_addr = 9'h0C4;
      @(negedge clk);
      check("b2b_gnt0", d_gnt, 1);
      next_cycle();
      d_addr = 9'h0C8;
      for (int i = 1; i <= MEM_LAT + 1; i++) begin
         @(negedge clk);
         check("b2b_busy", busy, (i <= MEM_LAT) ? 1 : 0);
         if (i == MEM_LAT + 1) begin
            check("b2b_gnt1", d_gnt, 1);
            check("b2b_rv0", d_rvalid, 1);
         end
         next_cycle();
      end
      d_req = 1'b0;
      wait_resp(1'b1, lat, data);
      check("b2b_lat1", lat, MEM_LAT + 1);

      // Reset while a fetch is in WAIT
      next_cycle();
      if_req = 1'b1; if_addr = 9'h040;
      @(negedge clk);
      check("rstw_gnt", if_gnt, 1);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("rstw_busy", busy, 0);
      check("rstw_gnt_blocked", if_gnt, 0);
      check("rstw_mem_en", mem_en, 0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rstw_regnt", if_gnt, 1);
      next_cycle();
      if_req = 1'b0;
      rv_cnt = 0; lat = -1;
      for (int i = 1; i <= MEM_LAT + 1; i++) begin
         @(negedge clk);
         if (if_rvalid) begin rv_cnt++; lat = i; end
         next_cycle();
      end
      check("rstw_rv_count", rv_cnt, 1);
      check("rstw_rv_at", lat, MEM_LAT + 1);

      // Both requesters held high: count who wins ten grants
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h010;
      if_req = 1'b1; if_addr = 9'h014;
      icnt = 0; dcnt = 0; first_if = -1;
      for (int i = 0; i < 80 && (icnt + dcnt) < 10; i++) begin
         @(negedge clk);
         if (d_gnt) dcnt++;
         if (if_gnt) begin
            icnt++;
            if (first_if < 0) first_if = icnt + dcnt;
         end
         next_cycle();
      end
      d_req = 1'b0; if_req = 1'b0;
`ifdef FETCH_ANTISTARVE_EN
      check("starve_if_grants", icnt, 10 / (STARVE_LIM + 1));
      check("starve_first_if", first_if, STARVE_LIM + 1);
`else
      check("strict_if_grants", icnt, 0);
`endif
      check("starve_total", icnt + dcnt, 10);
      repeat (MEM_LAT + 3) next_cycle();

      // Random traffic with one mid-run reset pulse
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         ig = if_gnt; dg = d_gnt;
         next_cycle();
         if (c == 700) rst = 1'b1;
         if (c == 702) rst = 1'b0;
         if (ig || (if_req && $urandom_range(0, 19) == 0)) if_req = 1'b0;
         if (!if_req && $urandom_range(0, 3) == 0) begin
            if_req = 1'b1;
            if_addr = ADDR_W'($urandom_range(0, 127) << 2);
         end
         if (dg || (d_req && $urandom_range(0, 19) == 0)) d_req = 1'b0;
         if (!d_req && $urandom_range(0, 3) == 0) begin
            d_req = 1'b1;
            d_we = 1'($urandom_range(0, 1));
            d_func3 = 3'($urandom_range(0, 7));
            d_addr = ADDR_W'($urandom_range(0, 127) << 2);
            d_wdata = $urandom;
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (MEM_LAT + 4) next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
